ascon_ct_serializer: RTL
========================

# ascon_ct_serializer

Read-side companion of the 128-bit cipher/tag register. Takes one cipher block (64 bits) or one tag (128 bits) per load and streams it out as big-endian 32-bit words over a valid/ready handshake toward the host/output interface. Signals the end of each item with `last_o` and `done_o`, and flags loads that arrive while a transfer is in progress.

## Interface
Parameters: none. Word width is fixed at 32 bits and item width at 128 bits.

Ports:
- `clock_i`  in  1  clock; all state updates on the rising edge.
- `resetb_i`  in  1  reset, asynchronous, active-low.
- `load_i`  in  1  load request; sampled only when `load_ready_o`=1.
- `kind_i`  in  1  item type: 0 = cipher block (uses `data_i[63:0]`), 1 = tag (uses `data_i[127:0]`).
- `data_i`  in  128  item to serialize; the cipher/tag register output.
- `load_ready_o`  out  1  block idle, load accepted.
- `word_o`  out  32  current output word.
- `valid_o`  out  1  `word_o` is valid.
- `ready_i`  in  1  downstream accepts the word.
- `last_o`  out  1  `word_o` is the final word of the item.
- `kind_o`  out  1  type of the item being sent.
- `done_o`  out  1  one-cycle pulse after the final word's handshake.
- `overflow_o`  out  1  sticky: `load_i` was seen while busy.
- `clear_i`  in  1  synchronous clear of `overflow_o`.

## Operation
- FSM with two states, IDLE and SEND. `load_ready_o` = (state == IDLE).
- IDLE to SEND: on `load_i`=1 at an edge.
  - Capture a 128-bit shift register: `data_i` for a tag; {`data_i[63:0]`, 64'h0} for a cipher block.
  - Set the remaining-word counter to 4 for a tag, 2 for a cipher block.
  - Latch `kind_o`.
- In SEND:
  - `word_o` = shift register [127:96].
  - `valid_o` = 1.
  - `last_o` = (remaining == 1).
- Handshake is `valid_o` & `ready_i` at an edge. On each handshake, shift left by 32 and decrement the counter.
- SEND to IDLE: on the handshake where remaining == 1. The next cycle has `valid_o`=0, `done_o`=1 and `load_ready_o`=1.
- Word order is most significant first.
  - Tag: `[127:96]`, `[95:64]`, `[63:32]`, `[31:0]`.
  - Cipher: `[63:32]`, `[31:0]`.
- Stall: while `valid_o`=1 and `ready_i`=0, `word_o`, `last_o` and `kind_o` hold stable and `valid_o` does not drop.
- `load_i`=1 while in SEND: the load is ignored, the transfer continues unchanged, and `overflow_o` is set.
- `clear_i`=1 zeroes `overflow_o`. When `clear_i` and a busy `load_i` occur in the same cycle, the clear wins.
- `ready_i` while `valid_o`=0 has no effect.
- `kind_i` and `data_i` are don't-care except in the load cycle.

## Timing
- Reset (`resetb_i`=0, any time, including mid-transfer):
  - State goes to IDLE, the shift register and counter clear, and `word_o` = 0.
  - `valid_o`, `last_o`, `kind_o`, `done_o` and `overflow_o` = 0. `load_ready_o` = 1.
  - A transfer interrupted by reset produces no `done_o`.
- Load accepted at edge N: the first word is valid from N+1. This is a registered output, with no combinational path from `data_i` to `word_o`.
- With `ready_i` held at 1:
  - A tag occupies edges N+1 to N+4.
  - `done_o` and `load_ready_o` are high in the cycle after edge N+4.
  - The next load can be accepted at edge N+5.
  - Throughput is 1 word per cycle inside an item, with a 1-cycle bubble between items.
- A cipher block with `ready_i` held at 1 gives `done_o` in the cycle after edge N+2.
- `done_o` lasts exactly 1 cycle. A load accepted in the `done_o` cycle is legal.
- `overflow_o` is registered and rises the cycle after the offending edge.

## Test plan
- Reset, then tag load with `data_i`=0x00112233_44556677_8899AABB_CCDDEEFF and `ready_i`=1:
  - words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF on 4 consecutive cycles;
  - `last_o` only on the 4th word; `kind_o`=1;
  - `done_o` pulse one cycle later.
- Cipher load with `data_i[63:0]`=0xDEADBEEF_01234567 (upper bits 0xFFFF...):
  - words 0xDEADBEEF, 0x01234567;
  - `last_o` on the 2nd word; `kind_o`=0.
- Tag load with `ready_i` toggled 0,0,1,0,1,1,0,1: each word is held stable through its stalls, exactly 4 handshakes occur, and no word is skipped or duplicated.
- Second overflow check with `load_i`=1 during SEND and different `data_i`:
  - the output stream is unchanged and `overflow_o`=1 next cycle;
  - `overflow_o` stays 1 until `clear_i`;
  - `clear_i` asserted together with another busy load leaves `overflow_o`=0.
- Reset asserted after the 2nd tag word: outputs go to their reset values immediately and there is no `done_o`. A new cipher load then streams correctly.
- Back-to-back items: load the next item in the `done_o` cycle. The first word appears on the following cycle, giving exactly one idle cycle between items.

Source files
------------

// File: rtl/ascon_ct_serializer.sv
// Streams a 64-bit cipher block or a 128-bit tag out as big-endian 32-bit words.
// Sticky overflow flags loads that arrive mid-transfer.
module ascon_ct_serializer (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         load_i,
  input  logic         kind_i,
  input  logic [127:0] data_i,
  output logic         load_ready_o,
  output logic [31:0]  word_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic         last_o,
  output logic         kind_o,
  output logic         done_o,
  output logic         overflow_o,
  input  logic         clear_i
);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t       state_q, state_d;
  logic [127:0] sr_q, sr_d;
  logic [2:0]   cnt_q, cnt_d;
  logic         kind_q, kind_d;
  logic         done_q, done_d;
  logic         ovf_q, ovf_d;

  // Handshake: a word transfers on a rising edge where valid_o and ready_i are
  // both 1; word_o/last_o/kind_o hold and valid_o stays high until that happens.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      kind_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    kind_d  = kind_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (load_i) begin
          state_d = S_SEND;
          sr_d    = kind_i ? data_i : {data_i[63:0], 64'h0};
          cnt_d   = kind_i ? 3'd4 : 3'd2;
          kind_d  = kind_i;
        end
      end
      S_SEND: begin
        if (ready_i) begin
          // Zeros shift in, so word_o returns to 0 once the item is drained.
          sr_d  = {sr_q[95:0], 32'h0};
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (clear_i) begin
      ovf_d = 1'b0;
    end else if ((state_q == S_SEND) && load_i) begin
      ovf_d = 1'b1;
    end
  end

  assign load_ready_o = (state_q == S_IDLE);
  assign valid_o      = (state_q == S_SEND);
  assign word_o       = sr_q[127:96];
  assign last_o       = (state_q == S_SEND) && (cnt_q == 3'd1);
  assign kind_o       = kind_q;
  assign done_o       = done_q;
  assign overflow_o   = ovf_q;

endmodule
